// File: rtl/debounce_multi.sv
// Multi-channel key/switch debouncer with a shared sample prescaler.
// Each channel: synchroniser, stability counter, registered rise/fall strobes.
module debounce_multi #(
    parameter int   CHANNELS    = 4,
    parameter int   DIV_MAX     = 29999,
    parameter int   STABLE_CNT  = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int PW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0]       DIV_TC   = PW'(DIV_MAX);
    localparam logic [CW-1:0]       CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

    logic [PW-1:0]       pre;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CW-1:0]       cnt     [CHANNELS];
    logic [CW-1:0]       cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] out_nxt;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;

    // tick is registered: it is high in the cycle after pre hits DIV_TC
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == DIV_TC) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + PW'(1);
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_VEC;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_nxt  = out;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick) begin
                if (s[i] == out[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_nxt[i]  = '0;
                    out_nxt[i]  = s[i];
                    rise_nxt[i] = s[i];
                    fall_nxt[i] = ~s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // strobes are registered alongside out so they coincide with the flip
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            out  <= INIT_VEC;
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            out  <= out_nxt;
            rise <= rise_nxt;
            fall <= fall_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed test-plan phases plus random toggling,
// checked every cycle against a sample-history model.
module tb_debounce_multi;

    localparam int DIV = 3;
    localparam int N   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_m, out_m, rise_m, fall_m;
    logic       tick_m;
    logic [3:0] in_c, out_c, rise_c, fall_c;
    logic       tick_c;
    logic [3:0] in_i, out_i, rise_i, fall_i;
    logic       tick_i;

    int checks   = 0;
    int failures = 0;

    debounce_multi #(
        .CHANNELS(4), .DIV_MAX(DIV), .STABLE_CNT(N),
        .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
    ) u_main (
        .clk(clk), .rst(rst), .in(in_m), .out(out_m),
        .rise(rise_m), .fall(fall_m), .tick(tick_m)
    );

    debounce_multi #(
        .CHANNELS(4), .DIV_MAX(0), .STABLE_CNT(1),
        .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
    ) u_corner (
        .clk(clk), .rst(rst), .in(in_c), .out(out_c),
        .rise(rise_c), .fall(fall_c), .tick(tick_c)
    );

    debounce_multi #(
        .CHANNELS(4), .DIV_MAX(DIV), .STABLE_CNT(N),
        .SYNC_STAGES(2), .INIT_LEVEL(1'b1)
    ) u_init (
        .clk(clk), .rst(rst), .in(in_i), .out(out_i),
        .rise(rise_i), .fall(fall_i), .tick(tick_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model state
    bit          started = 0;
    int          k;
    bit          m_tick, c_tick;
    logic [3:0]  m_d0, m_d1, m_out, m_rise, m_fall;
    logic [31:0] hist [4];
    int          len  [4];
    logic [3:0]  c_l0, c_l1, c_l2, c_out, c_rise, c_fall;
    int          rcnt [4];
    int          fcnt [4];
    bit          all_rise_seen = 0;

    task automatic model_step();
        logic [3:0]  s_old;
        bit          t_old;
        logic [31:0] mask;
        s_old = m_d1;
        t_old = m_tick;
        mask  = (32'd1 << N) - 32'd1;
        if (!rst) begin
            started = 1;
            k = 0;
            m_tick = 0; c_tick = 0;
            m_d0 = 0; m_d1 = 0;
            m_out = 0; m_rise = 0; m_fall = 0;
            for (int i = 0; i < 4; i++) begin
                hist[i] = 0;
                len[i]  = 0;
            end
            c_l0 = 0; c_l1 = 0; c_l2 = 0;
            c_out = 0; c_rise = 0; c_fall = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (t_old) begin
                for (int i = 0; i < 4; i++) begin
                    hist[i] = {hist[i][30:0], s_old[i]};
                    len[i]++;
                    // flip once the last N samples all oppose the output
                    if (len[i] >= N &&
                        (hist[i] & mask) == (m_out[i] ? 32'd0 : mask)) begin
                        m_out[i] = ~m_out[i];
                        if (m_out[i]) m_rise[i] = 1'b1;
                        else          m_fall[i] = 1'b1;
                        hist[i] = 0;
                        len[i]  = 0;
                    end
                end
            end
            k++;
            m_tick = (k % (DIV + 1)) == 0;
            c_tick = (k >= 1);
            m_d1 = m_d0;
            m_d0 = in_m;
            c_l2 = c_l1;
            c_l1 = c_l0;
            c_l0 = in_c;
            c_rise = c_l2 & ~c_out;
            c_fall = ~c_l2 & c_out;
            c_out  = c_l2;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (started) begin
            chk("tick", tick_m, m_tick);
            chk("out", out_m, m_out);
            chk("rise", rise_m, m_rise);
            chk("fall", fall_m, m_fall);
            chk("c_tick", tick_c, c_tick);
            chk("c_out", out_c, c_out);
            chk("c_rise", rise_c, c_rise);
            chk("c_fall", fall_c, c_fall);
            chk("i_out", out_i, 4'hF);
            chk("i_strobe", {rise_i, fall_i}, 8'h00);
            for (int i = 0; i < 4; i++) begin
                rcnt[i] += int'(rise_m[i]);
                fcnt[i] += int'(fall_m[i]);
            end
            if (rise_m == 4'hF) all_rise_seen = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            in_c = 4'($urandom);
        end
    end

    task automatic clr_counts();
        for (int i = 0; i < 4; i++) begin
            rcnt[i] = 0;
            fcnt[i] = 0;
        end
    endtask

    initial begin
        int lat;
        bit done;
        bit pat [8];
        pat = '{1, 0, 1, 1, 0, 1, 1, 1};
        rst  = 1'b0;
        in_m = 4'h0;
        in_i = 4'hF;
        in_c = 4'h0;
        clr_counts();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // idle
        repeat (40) @(negedge clk);
        chk("idle_out", out_m, 4'h0);
        chk("idle_strobes", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3]
            + fcnt[0] + fcnt[1] + fcnt[2] + fcnt[3], 0);

        // clean press on ch0
        clr_counts();
        in_m[0] = 1'b1;
        lat  = 0;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            #2;
            lat++;
            if (out_m[0]) done = 1;
        end
        chk("press_done", done, 1);
        chk("press_lat_min", lat >= 11, 1);
        chk("press_lat_max", lat <= 14, 1);
        repeat (10) @(negedge clk);
        chk("press_rise0", rcnt[0], 1);
        chk("press_others", out_m[3:1], 3'b000);

        // glitch on ch1: high for exactly two sample periods
        clr_counts();
        in_m[1] = 1'b1;
        repeat (8) @(negedge clk);
        in_m[1] = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_out1", out_m[1], 0);
        chk("glitch_strobe1", rcnt[1] + fcnt[1], 0);

        // bounce on ch2, one sample per value
        clr_counts();
        for (int p = 0; p < 8; p++) begin
            in_m[2] = pat[p];
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("bounce_out2", out_m[2], 1);
        chk("bounce_rise2", rcnt[2], 1);
        in_m[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("release_out2", out_m[2], 0);
        chk("release_fall2", fcnt[2], 1);

        // simultaneous press on all channels
        in_m = 4'h0;
        repeat (24) @(negedge clk);
        all_rise_seen = 0;
        in_m = 4'hF;
        repeat (24) @(negedge clk);
        chk("simul_out", out_m, 4'hF);
        chk("simul_rise", all_rise_seen, 1);

        // reset in the middle of a falling count
        clr_counts();
        in_m = 4'h0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_out", out_m, 4'h0);
        chk("rst_fall", fall_m, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_fall", fcnt[0] + fcnt[1] + fcnt[2] + fcnt[3], 0);

        // random toggling
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 11) == 0) in_m[i] = ~in_m[i];
            end
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
